// File: rtl/lite_v1_issue_if.sv
// Fetch/issue bus for lite_v1_issue: ROM read port plus valid/ready instruction handshake.
// master = issue front end, slave = ROM + execute unit side.
interface lite_v1_issue_if #(
  parameter int ADDR_W = 8
);
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [19:0]       mem_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        opcode;
  logic [7:0]        d1;
  logic [9:0]        d2;

  modport master (
    output mem_en, mem_addr, out_valid, opcode, d1, d2,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_en, mem_addr, out_valid, opcode, d1, d2,
    output mem_data, out_ready
  );
endinterface

// File: rtl/lite_v1_issue.sv
// lite_v1 instruction fetch/decode/issue front end: ROM fetch, field split, valid/ready issue, HALT stop.
// Optional single-step debug gate enabled by defining LITE_ISSUE_STEP_EN (adds the step port).
module lite_v1_issue #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef LITE_ISSUE_STEP_EN
  input  logic             step,
`endif
  lite_v1_issue_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issue_cnt
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, HALTED, STALL} state_t;

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              step_ok;

`ifdef LITE_ISSUE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  assign bus.mem_addr = pc;

  // STALL is only reachable when step_ok can be low, i.e. in the single-step build.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= START_PC;
      bus.mem_en    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.opcode    <= '0;
      bus.d1        <= '0;
      bus.d2        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      issue_cnt     <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            pc         <= START_PC;
            issue_cnt  <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            bus.mem_en <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          bus.mem_en <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (bus.mem_data[19:18] == 2'b11) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= HALTED;
          end else begin
            bus.opcode    <= bus.mem_data[19:18];
            bus.d1        <= bus.mem_data[17:10];
            bus.d2        <= bus.mem_data[9:0];
            bus.out_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            pc            <= pc + 1'b1;
            if (issue_cnt != '1) issue_cnt <= issue_cnt + 1'b1;
            if (step_ok) begin
              bus.mem_en <= 1'b1;
              state      <= FETCH;
            end else begin
              state <= STALL;
            end
          end
        end
        STALL: begin
          if (step_ok) begin
            bus.mem_en <= 1'b1;
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lite_v1_issue.sv
// Directed bench for lite_v1_issue: scoreboard on the issue handshake plus cycle-exact checks.
// A second instance (ADDR_W=2, START_ADDR=3, CNT_W=2) covers PC wrap and counter saturation.
module tb_lite_v1_issue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic step = 1'b1;
  logic busy, done, busy2, done2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] rom  [256];
  logic [19:0] rom2 [4];

  always #5 clk = ~clk;

  lite_v1_issue_if #(.ADDR_W(8)) bus ();
  lite_v1_issue_if #(.ADDR_W(2)) bus2 ();

  lite_v1_issue #(.ADDR_W(8), .START_ADDR(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef LITE_ISSUE_STEP_EN
    .step(step),
`endif
    .bus(bus), .busy(busy), .done(done), .issue_cnt(cnt)
  );

  lite_v1_issue #(.ADDR_W(2), .START_ADDR(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
`ifdef LITE_ISSUE_STEP_EN
    .step(step),
`endif
    .bus(bus2), .busy(busy2), .done(done2), .issue_cnt(cnt2)
  );

  // synchronous ROMs: data the cycle after mem_en
  always @(posedge clk) if (bus.mem_en) bus.mem_data <= rom[bus.mem_addr];
  always @(posedge clk) if (bus2.mem_en) bus2.mem_data <= rom2[bus2.mem_addr];

  function automatic logic [19:0] w(input logic [1:0] op, input logic [7:0] a, input logic [9:0] b);
    return {op, a, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  // scoreboard: every completed handshake must match the next expected word
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_issue", 32'd1, 32'd0);
      end else begin
        chk("sb_issue", {12'd0, bus.opcode, bus.d1, bus.d2}, {12'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < 4; i++) rom2[i] = '0;
    bus.out_ready  = 1'b0;
    bus2.out_ready = 1'b1;

    // 1) reset values
    tick(); tick();
    rst = 1'b0;
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_addr", {24'd0, bus.mem_addr}, 32'd0);
    chk("rst_fields", {12'd0, bus.opcode, bus.d1, bus.d2}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_cnt", {16'd0, cnt}, 32'd0);

    // 2) two issues then HALT, out_ready held high
    rom[0] = w(2'b00, 8'h15, 10'h3FF);
    rom[1] = w(2'b01, 8'hAA, 10'h155);
    rom[2] = w(2'b11, 8'h00, 10'h000);
    exp_q.push_back(rom[0]);
    exp_q.push_back(rom[1]);
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_fetch0", {23'd0, bus.mem_en, bus.mem_addr}, {23'd0, 1'b1, 8'd0});
    chk("t2_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t2_wait_mem_en", {31'd0, bus.mem_en}, 32'd0);
    tick();
    chk("t2_issue0", {11'd0, bus.out_valid, bus.opcode, bus.d1, bus.d2}, {11'd0, 1'b1, w(2'b00, 8'h15, 10'h3FF)});
    tick();
    chk("t2_fetch1", {23'd0, bus.mem_en, bus.mem_addr}, {23'd0, 1'b1, 8'd1});
    tick(); tick();
    chk("t2_issue1", {11'd0, bus.out_valid, bus.opcode, bus.d1, bus.d2}, {11'd0, 1'b1, w(2'b01, 8'hAA, 10'h155)});
    tick(); tick(); tick();
    chk("t2_done", {30'd0, busy, done}, {30'd0, 2'b01});
    chk("t2_cnt", {16'd0, cnt}, 32'd2);
    chk("t2_halt_no_valid", {31'd0, bus.out_valid}, 32'd0);

    // 3) back-pressure: five cycles of out_ready=0 in ISSUE
    rom[0] = w(2'b10, 8'h3C, 10'h2A5);
    rom[1] = w(2'b11, 8'h00, 10'h000);
    exp_q.push_back(rom[0]);
    bus.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold", {10'd0, bus.out_valid, bus.mem_en, bus.opcode, bus.d1, bus.d2},
          {10'd0, 1'b1, 1'b0, w(2'b10, 8'h3C, 10'h2A5)});
      chk("t3_pc", {24'd0, bus.mem_addr}, 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("t3_after_hs", {22'd0, bus.out_valid, bus.mem_en, bus.mem_addr}, {22'd0, 1'b0, 1'b1, 8'd1});
    chk("t3_cnt", {16'd0, cnt}, 32'd1);
    wait_done("t3_done");

    // 5) start while busy ignored, then rst aborts a pending issue
    rom[0] = w(2'b00, 8'h01, 10'h002);
    rom[1] = w(2'b01, 8'h03, 10'h004);
    rom[2] = w(2'b11, 8'h00, 10'h000);
    exp_q.push_back(rom[0]);
    start = 1'b1;
    tick();
    chk("t5_fetch0", {23'd0, bus.mem_en, bus.mem_addr}, {23'd0, 1'b1, 8'd0});
    tick();
    start = 1'b0;
    tick();
    chk("t5_issue0", {31'd0, bus.out_valid}, 32'd1);
    tick();
    chk("t5_pc_continues", {23'd0, bus.mem_en, bus.mem_addr}, {23'd0, 1'b1, 8'd1});
    bus.out_ready = 1'b0;
    tick(); tick();
    chk("t5_issue1", {11'd0, bus.out_valid, bus.opcode, bus.d1, bus.d2}, {11'd0, 1'b1, w(2'b01, 8'h03, 10'h004)});
    chk("t5_cnt_pre", {16'd0, cnt}, 32'd1);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_state", {28'd0, bus.out_valid, bus.mem_en, busy, done}, 32'd0);
    chk("t5_rst_cnt_pc", {8'd0, cnt, bus.mem_addr}, 32'd0);
    tick();
    chk("t5_idle_stays", {30'd0, bus.mem_en, busy}, 32'd0);

    // 4) wrap: ADDR_W=2, START_ADDR=3 fetches 3 then 0
    rom2[3] = w(2'b00, 8'h81, 10'h001);
    rom2[0] = w(2'b11, 8'h00, 10'h000);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("t4_fetch3", {29'd0, bus2.mem_en, bus2.mem_addr}, {29'd0, 1'b1, 2'd3});
    tick(); tick();
    chk("t4_issue", {11'd0, bus2.out_valid, bus2.opcode, bus2.d1, bus2.d2}, {11'd0, 1'b1, w(2'b00, 8'h81, 10'h001)});
    tick();
    chk("t4_fetch0", {29'd0, bus2.mem_en, bus2.mem_addr}, {29'd0, 1'b1, 2'd0});
    tick(); tick();
    chk("t4_done", {28'd0, busy2, done2, cnt2}, {28'd0, 1'b0, 1'b1, 2'd1});

    // saturation: CNT_W=2 counter stops at 3 over six issues
    for (int i = 0; i < 4; i++) rom2[i] = w(2'b10, 8'(i), 10'(i));
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("sat_restart", {30'd0, done2, cnt2 == 2'd0}, {30'd0, 1'b0, 1'b1});
    for (int i = 0; i < 18; i++) tick();
    chk("sat_cnt", {28'd0, busy2, cnt2}, {28'd0, 1'b1, 2'd3});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat_rst", {28'd0, busy2, cnt2}, 32'd0);

`ifdef LITE_ISSUE_STEP_EN
    // 6) single-step: no fetch until step after the first handshake
    rom[0] = w(2'b00, 8'h11, 10'h022);
    rom[1] = w(2'b01, 8'h33, 10'h044);
    rom[2] = w(2'b11, 8'h00, 10'h000);
    exp_q.push_back(rom[0]);
    exp_q.push_back(rom[1]);
    step = 1'b0;
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t6_issue0", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_stall", {30'd0, bus.out_valid, bus.mem_en}, 32'd0);
    end
    step = 1'b1;
    tick();
    chk("t6_fetch1", {23'd0, bus.mem_en, bus.mem_addr}, {23'd0, 1'b1, 8'd1});
    wait_done("t6_done");
`endif

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
